// File: rtl/riscstrong_pkg.sv
// Shared defaults, FSM state encoding and next-PC source encoding for the fetch PC unit.
package riscstrong_pkg;

  localparam int          XLEN_DEFAULT      = 32;
  localparam logic [63:0] RESET_VEC_DEFAULT = 64'h0;
  localparam logic [63:0] TRAP_VEC_DEFAULT  = 64'h4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_t;

  // Which source won the RUN-state priority mux this cycle.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_STALL,
    SEL_HALT,
    SEL_REDIRECT,
    SEL_MISALIGN,
    SEL_TRAP
  } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux (trap > redirect > halt > stall > increment) and redirect alignment check.
// PC_COMPRESSED_EN selects +2/+4 stepping and a 2-byte alignment boundary; otherwise +4 and 4-byte.
module pc_next_sel
  import riscstrong_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT[XLEN-1:0]
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            trap_req_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            halt_req_i,
  input  logic            stall_i,
  input  logic            is_compressed_i,
  output pc_sel_t         sel_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic [XLEN-1:0] epc_next_o
);

  logic misaligned;

`ifdef PC_COMPRESSED_EN
  assign pc_inc_o   = is_compressed_i ? (pc_i + XLEN'(2)) : (pc_i + XLEN'(4));
  assign misaligned = redirect_target_i[0];
`else
  logic unused_cmp;
  assign unused_cmp = is_compressed_i;
  assign pc_inc_o   = pc_i + XLEN'(4);
  assign misaligned = |redirect_target_i[1:0];
`endif

  always_comb begin
    sel_o      = SEL_SEQ;
    pc_next_o  = pc_inc_o;
    epc_next_o = pc_i;
    if (trap_req_i) begin
      sel_o     = SEL_TRAP;
      pc_next_o = TRAP_VEC;
    end else if (redirect_valid_i) begin
      if (misaligned) begin
        // A bad target traps immediately and is recorded as the faulting address.
        sel_o      = SEL_MISALIGN;
        pc_next_o  = TRAP_VEC;
        epc_next_o = redirect_target_i;
      end else begin
        sel_o     = SEL_REDIRECT;
        pc_next_o = redirect_target_i;
      end
    end else if (halt_req_i) begin
      sel_o     = SEL_HALT;
      pc_next_o = pc_i;
    end else if (stall_i) begin
      sel_o     = SEL_STALL;
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with BOOT/RUN/HALT FSM; every event lands on pc one clock later, all outputs registered.
// Optional 16-bit instruction support via PC_COMPRESSED_EN (handled in pc_next_sel).
module pc_unit
  import riscstrong_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT[XLEN-1:0],
  parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset1,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            is_compressed,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_exc,
  output logic            halted
);

  pc_state_t       state_q;
  logic [XLEN-1:0] pc_q, epc_q;
  logic            pc_valid_q, misalign_q, halted_q;

  pc_sel_t         sel_d;
  logic [XLEN-1:0] pc_d, pc_inc_d, epc_d;

  pc_next_sel #(
    .XLEN    (XLEN),
    .TRAP_VEC(TRAP_VEC)
  ) u_next_sel (
    .pc_i             (pc_q),
    .trap_req_i       (trap_req),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .halt_req_i       (halt_req),
    .stall_i          (stall),
    .is_compressed_i  (is_compressed),
    .sel_o            (sel_d),
    .pc_next_o        (pc_d),
    .pc_inc_o         (pc_inc_d),
    .epc_next_o       (epc_d)
  );

  always_ff @(posedge clk) begin
    if (reset1) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          // The boot cycle presents RESET_VEC as invalid; RUN starts on the next word.
          state_q    <= RUN;
          pc_q       <= pc_inc_d;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          pc_q <= pc_d;
          unique case (sel_d)
            SEL_TRAP: epc_q <= epc_d;
            SEL_MISALIGN: begin
              epc_q      <= epc_d;
              misalign_q <= 1'b1;
            end
            SEL_HALT: begin
              state_q    <= HALT;
              halted_q   <= 1'b1;
              pc_valid_q <= 1'b0;
            end
            default: ;
          endcase
        end
        HALT: begin
          // Redirects are ignored here; only a trap or resume leaves HALT.
          if (trap_req) begin
            state_q    <= RUN;
            pc_q       <= TRAP_VEC;
            epc_q      <= pc_q;
            halted_q   <= 1'b0;
            pc_valid_q <= 1'b1;
          end else if (resume) begin
            state_q    <= RUN;
            halted_q   <= 1'b0;
            pc_valid_q <= 1'b1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign epc          = epc_q;
  assign misalign_exc = misalign_q;
  assign halted       = halted_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning program counter width in bits (legal values 32 and 64).
REQ-002 The module SHALL have parameter RESET_VEC, default 0, meaning PC value loaded by reset.
REQ-003 The module SHALL have parameter TRAP_VEC, default 32'h0000_0004 (zero-extended to XLEN), meaning PC value loaded on trap.
REQ-004 clk  input  1  — sole clock; all state SHALL update on its rising edge.
REQ-005 reset1  input  1  — reset, synchronous and active-high.
REQ-006 stall  input  1  — hold the PC this cycle.
REQ-007 redirect_valid  input  1  — branch or jump taken this cycle.
REQ-008 redirect_target  input  XLEN  — branch or jump destination.
REQ-009 trap_req  input  1  — external exception or interrupt request.
REQ-010 halt_req  input  1  — enter HALT (debug or WFI).
REQ-011 resume  input  1  — leave HALT.
REQ-012 is_compressed  input  1  — current instruction is 16-bit; used only with PC_COMPRESSED_EN.
REQ-013 pc  output  XLEN  — current fetch address, registered.
REQ-014 pc_valid  output  1  — pc is a valid fetch address this cycle.
REQ-015 epc  output  XLEN  — PC captured at the last trap.
REQ-016 misalign_exc  output  1  — one-cycle pulse: redirect target was misaligned.
REQ-017 halted  output  1  — FSM is in HALT.

Function
REQ-018 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-019 BOOT SHALL last exactly one cycle after reset deasserts, with pc=RESET_VEC and pc_valid=0, then go to RUN.
REQ-020 In RUN, the per-cycle priority SHALL be: trap_req > redirect_valid > halt_req > stall > sequential increment.
REQ-021 On trap_req, the block SHALL set pc<=TRAP_VEC and epc<=pc, regardless of stall.
REQ-022 On an aligned redirect, the block SHALL set pc<=redirect_target, even if stall=1 (redirect overrides stall).
REQ-023 On a misaligned redirect, the block SHALL set pc<=TRAP_VEC, set epc<=redirect_target, and pulse misalign_exc for one cycle.
REQ-024 Alignment SHALL be tested on redirect_target[1:0]!=0, or on redirect_target[0] when PC_COMPRESSED_EN is defined.
REQ-025 On halt_req, the FSM SHALL go to HALT with pc held; halted=1 and pc_valid=0 from the next cycle.
REQ-026 In HALT, pc SHALL hold until resume=1 or trap_req=1; resume returns to RUN with pc unchanged, and trap exits through REQ-021.
REQ-027 redirect_valid in HALT SHALL be ignored.
REQ-028 On stall with no higher-priority event, pc SHALL hold and pc_valid SHALL remain 1.
REQ-029 The sequential increment SHALL be pc<=pc+4 in XLEN-bit modular arithmetic: carry discarded, all-ones-minus-3 wraps to 0, no flag.
REQ-030 Latency from any event input to the new pc SHALL be exactly one clock; pc SHALL have no combinational path from any input.

Reset
REQ-031 reset1=1 at a clock edge SHALL set pc=RESET_VEC, epc=0, misalign_exc=0, halted=0, pc_valid=0 and state=BOOT.
REQ-032 reset1 SHALL override every other input, including mid-trap and HALT.

Configuration
REQ-033 The macro PC_COMPRESSED_EN SHALL control support for 16-bit instructions.
REQ-034 With PC_COMPRESSED_EN defined, the increment SHALL be +2 when is_compressed=1 and +4 otherwise, and alignment SHALL use a 2-byte boundary.
REQ-035 Without PC_COMPRESSED_EN, is_compressed SHALL be ignored, the increment SHALL always be +4, and alignment SHALL use a 4-byte boundary.

Structure
REQ-036 Package riscstrong_pkg SHALL hold the XLEN default, RESET_VEC/TRAP_VEC defaults, and the state enum pc_state_t {BOOT, RUN, HALT}.
REQ-037 Sub-module pc_next_sel SHALL hold the combinational priority mux and alignment check.
REQ-038 pc_unit SHALL hold the registers and the FSM.

Verification
REQ-039 reset1=1 for 2 cycles, then 0 -> pc=0 and pc_valid=0 for one cycle, then pc=0x4, 0x8, 0xC on successive cycles.
REQ-040 pc=0x100, stall=1 and redirect_valid=1 with target=0x200 in the same cycle -> pc=0x200 next cycle; stall alone -> pc holds at 0x200.
REQ-041 Redirect to target 0x202 without the macro -> pc=TRAP_VEC, epc=0x202, misalign_exc=1 for exactly one cycle; with PC_COMPRESSED_EN -> pc=0x202, no exception.
REQ-042 pc=0x40, trap_req=1 and redirect_valid=1 together -> pc=0x4 and epc=0x40.
REQ-043 halt_req at pc=0x80 -> halted=1, pc_valid=0, pc stays 0x80 for 10 cycles despite redirect_valid; resume -> RUN, then pc=0x84.
REQ-044 pc=0xFFFF_FFFC with XLEN=32 -> pc=0 next cycle; reset1 asserted while in HALT -> BOOT, pc=RESET_VEC.
